fft16_digit_reverse_buffer: RTL

//  Output reorder buffer behind the last radix-4 butterfly stage of the 16-point FFT.
//  - Accepts 4 complex IEEE-754 single-precision results per beat, in radix-4 digit-reversed order.
//  - Streams the 16 bins X[0..15] in natural order, one per cycle, over a valid/ready interface.
//  - Reader for the stage-2 butterfly write order. Holds data only; no arithmetic on samples.

---
 rtl/fft16_pkg.sv | 24 ++
 rtl/fft16_sample_bank.sv | 25 ++
 rtl/fft16_digit_reverse_buffer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fft16_pkg.sv
// Shared constants, sample type and address helper for the 16-point FFT reorder buffer.
package fft16_pkg;

    localparam int DATA_W = 32;
    localparam int N_PTS  = 16;
    localparam int RADIX  = 4;
    localparam int ADDR_W = 4;

    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } cplx_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Lane k of butterfly beat m lands on natural bin index m + 4*k.
    function automatic logic [ADDR_W-1:0] digit_rev_addr(input logic [1:0] m, input logic [1:0] k);
        return ADDR_W'(m) + (ADDR_W'(k) << 2);
    endfunction

endpackage

// File: rtl/fft16_sample_bank.sv
// 16-entry complex register file: one 4-lane digit-reversed write port, one natural-order read port.
module fft16_sample_bank
    import fft16_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [1:0]            wr_m,
    input  cplx_t [RADIX-1:0]     wr_lanes,
    input  logic [ADDR_W-1:0]     rd_addr,
    output cplx_t                 rd_data
);

    cplx_t mem [N_PTS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < RADIX; k++) begin
                mem[digit_rev_addr(wr_m, 2'(k))] <= wr_lanes[k];
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft16_digit_reverse_buffer.sv
// Reorders radix-4 digit-reversed FFT results into natural-order bins over valid/ready.
// Define FFT16_PINGPONG_EN for a two-bank build that fills one bank while draining the other.
module fft16_digit_reverse_buffer
    import fft16_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DATA_W-1:0]   in_k_real,
    input  logic [4*DATA_W-1:0]   in_k_im,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_real,
    output logic [DATA_W-1:0]     out_im,
    output logic [3:0]            out_idx,
    output logic                  out_last
);

    cplx_t [RADIX-1:0]   wr_lanes;
    cplx_t               rd_data;
    logic [ADDR_W-1:0]   rd_addr;
    logic [1:0]          beat_m;
    logic                accept;
    logic                done_wr;
    logic                last_hs;
    logic                start_read;

    always_comb begin
        for (int k = 0; k < RADIX; k++) begin
            wr_lanes[k].re = in_k_real[k*DATA_W +: DATA_W];
            wr_lanes[k].im = in_k_im[k*DATA_W +: DATA_W];
        end
    end

    assign accept  = in_valid && in_ready;
    assign done_wr = accept && (beat_m == 2'd3);
    assign last_hs = out_valid && out_ready && (out_idx == 4'(N_PTS-1));
    assign rd_addr = start_read ? '0 : out_idx + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_m <= '0;
        end else if (accept) begin
            beat_m <= beat_m + 2'd1;
        end
    end

`ifdef FFT16_PINGPONG_EN
    cplx_t       bank_rd [2];
    logic        wb;
    logic        rb;
    logic        rb_nx;
    logic [1:0]  full;
    logic [1:0]  full_nx;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft16_sample_bank u_bank (
            .clk      (clk),
            .we       (accept && (wb == 1'(b))),
            .wr_m     (beat_m),
            .wr_lanes (wr_lanes),
            .rd_addr  (rd_addr),
            .rd_data  (bank_rd[b])
        );
    end

    // A bank stays full from write completion until its last bin is handed off.
    assign in_ready   = !full[wb];
    assign rb_nx      = last_hs ? ~rb : rb;
    assign start_read = (!out_valid || last_hs) &&
                        (full[rb_nx] || (done_wr && (wb == rb_nx)));
    assign rd_data    = bank_rd[rb_nx];

    always_comb begin
        full_nx = full;
        if (done_wr) full_nx[wb] = 1'b1;
        if (last_hs) full_nx[rb] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= '0;
            wb   <= 1'b0;
            rb   <= 1'b0;
        end else begin
            full <= full_nx;
            rb   <= rb_nx;
            if (done_wr) wb <= ~wb;
        end
    end
`else
    state_t state;
    state_t state_nx;

    fft16_sample_bank u_bank (
        .clk      (clk),
        .we       (accept),
        .wr_m     (beat_m),
        .wr_lanes (wr_lanes),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        start_read = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && (beat_m == 2'd3)) begin
                    state_nx   = DRAIN;
                    start_read = 1'b1;
                end
            end
            DRAIN: begin
                if (last_hs) state_nx = FILL;
            end
            default: state_nx = FILL;
        endcase
    end
`endif

    // A new frame takes priority so the two-bank build can chain frames without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_real  <= '0;
            out_im    <= '0;
        end else if (start_read) begin
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_real  <= rd_data.re;
            out_im    <= rd_data.im;
        end else if (last_hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_idx   <= out_idx + 4'd1;
            out_last  <= (out_idx == 4'(N_PTS-2));
            out_real  <= rd_data.re;
            out_im    <= rd_data.im;
        end
    end

endmodule
